// File: rtl/if_pkg.sv
// Shared widths, constants and queue-entry type for the instruction-fetch front end.
package if_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            filled;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_slot_array.sv
// DEPTH-entry register file of fetch slots: PC written at allocation,
// instruction written at fill, filled bit qualifies the entry.
module fetch_slot_array
    import if_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alloc_en_i,
    input  logic [$clog2(DEPTH)-1:0] alloc_idx_i,
    input  logic [XLEN-1:0]          alloc_pc_i,
    input  logic                     fill_en_i,
    input  logic [$clog2(DEPTH)-1:0] fill_idx_i,
    input  logic [XLEN-1:0]          fill_instr_i,
    input  logic                     clr_en_i,
    input  logic [$clog2(DEPTH)-1:0] clr_idx_i,
    input  logic                     flush_i,
    input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
    output fetch_entry_t             rd_entry_o
);

    logic [XLEN-1:0]  pc_q    [DEPTH];
    logic [XLEN-1:0]  instr_q [DEPTH];
    logic [DEPTH-1:0] filled_q;
    logic [DEPTH-1:0] filled_d;

    always_comb begin
        // NOTE: start from the held value so every path assigns filled_d and no latch is inferred.
        filled_d = filled_q;
        if (clr_en_i)   filled_d[clr_idx_i]   = 1'b0;
        if (fill_en_i)  filled_d[fill_idx_i]  = 1'b1;
        if (alloc_en_i) filled_d[alloc_idx_i] = 1'b0;
        if (flush_i)    filled_d = '0;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        // NOTE: non-blocking assignments keep every register updating from pre-edge values.
        if (rst_n) filled_q <= '0;
        else       filled_q <= filled_d;
    end

    // NOTE: payload storage is deliberately not reset; an entry is meaningful only while filled.
    always_ff @(posedge clk) begin
        if (alloc_en_i) pc_q[alloc_idx_i]   <= alloc_pc_i;
        if (fill_en_i)  instr_q[fill_idx_i] <= fill_instr_i;
    end

    always_comb begin
        rd_entry_o.pc     = pc_q[rd_idx_i];
        rd_entry_o.instr  = instr_q[rd_idx_i];
        rd_entry_o.filled = filled_q[rd_idx_i];
    end

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch front end: issues in-order imem requests, queues returned instructions
// with their PCs for decode, and drops stale responses after a redirect.
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc_in,
    output logic            pc_en,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect,
    output logic            id_valid,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    input  logic            id_ready
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] ONE     = PW'(1);

    logic [PW-1:0] alloc_q, alloc_d;
    logic [PW-1:0] fill_q,  fill_d;
    logic [PW-1:0] rd_q,    rd_d;
    logic [PW-1:0] drop_q,  drop_d;
    logic [PW-1:0] occupancy;
    logic [PW-1:0] inflight;
    logic          rsp_fill;
    logic          deq;
    fetch_entry_t  head;

    assign occupancy = alloc_q - rd_q;
    assign inflight  = alloc_q - fill_q;

    // Request window uses registered occupancy, so a dequeue only reopens it next cycle.
    assign imem_req_valid = !rst_n && !redirect && (occupancy < DEPTH_P);
    assign imem_req_addr  = pc_in;
    assign pc_en          = imem_req_valid && imem_req_ready;

    assign rsp_fill = imem_rsp_valid && !redirect && (drop_q == '0) && (inflight != '0);
    assign id_valid = !rst_n && !redirect && head.filled && (occupancy != '0);
    assign deq      = id_valid && id_ready;
    assign id_instr = id_valid ? head.instr : NOP_INSTR;
    assign id_pc    = head.pc;

    always_comb begin
        alloc_d = alloc_q;
        fill_d  = fill_q;
        rd_d    = rd_q;
        drop_d  = drop_q;
        if (redirect) begin
            // Every outstanding request becomes stale; a response arriving now is the first one dropped.
            fill_d = alloc_q;
            rd_d   = alloc_q;
            drop_d = drop_q + inflight;
            if (imem_rsp_valid && (drop_d != '0)) drop_d = drop_d - ONE;
        end else begin
            if (pc_en)    alloc_d = alloc_q + ONE;
            if (rsp_fill) fill_d = fill_q + ONE;
            else if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - ONE;
            if (deq)      rd_d = rd_q + ONE;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            alloc_q <= '0;
            fill_q  <= '0;
            rd_q    <= '0;
            drop_q  <= '0;
        end else begin
            alloc_q <= alloc_d;
            fill_q  <= fill_d;
            rd_q    <= rd_d;
            drop_q  <= drop_d;
        end
    end

    fetch_slot_array #(
        .DEPTH(DEPTH)
    ) u_slots (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc_en_i  (pc_en),
        .alloc_idx_i (alloc_q[IW-1:0]),
        .alloc_pc_i  (pc_in),
        .fill_en_i   (rsp_fill),
        .fill_idx_i  (fill_q[IW-1:0]),
        .fill_instr_i(imem_rsp_data),
        .clr_en_i    (deq),
        .clr_idx_i   (rd_q[IW-1:0]),
        .flush_i     (redirect),
        .rd_idx_i    (rd_q[IW-1:0]),
        .rd_entry_o  (head)
    );

    // Memory may only answer requests that are actually outstanding.
    a_rsp_outstanding: assert property (@(posedge clk) disable iff (rst_n)
        imem_rsp_valid |-> ((inflight != '0) || (drop_q != '0)));

    a_drop_bound: assert property (@(posedge clk) disable iff (rst_n)
        drop_q <= DEPTH_P);

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: directed vector table, hand-written
// corner sequences, and randomized traffic against a queue-based reference model.
module tb_if_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_in;
    logic        pc_en;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready;

    if_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_in         (pc_in),
        .pc_en         (pc_en),
        .imem_req_valid(imem_req_valid),
        .imem_req_addr (imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect      (redirect),
        .id_valid      (id_valid),
        .id_instr      (id_instr),
        .id_pc         (id_pc),
        .id_ready      (id_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a ^ 32'hDEAD_0000) + 32'h13;
    endfunction

    // Reference model: ordered list of queued fetches plus a count of stale responses to discard.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        bit          filled;
    } m_entry_t;
    m_entry_t mq[$];
    int       m_drop;

    // Memory agent: in-order outstanding requests with the cycle each may answer.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;
    mem_req_t memq[$];

    int   cyc      = 0;
    bit   auto_mem = 0;
    bit   auto_pc  = 0;
    bit   rsp_always = 1;
    int   lat_lo   = 1;
    int   lat_hi   = 1;
    logic        last_pe, last_rv, last_iv;
    logic [31:0] last_pc, last_instr;

    task automatic model_step();
        bit exp_rv, exp_pe, exp_iv;
        int unf;
        exp_rv = !redirect && (mq.size() < DEPTH);
        exp_pe = exp_rv && imem_req_ready;
        exp_iv = !redirect && (mq.size() > 0) && mq[0].filled;
        check("req_valid", imem_req_valid, exp_rv);
        check("pc_en", pc_en, exp_pe);
        check("id_valid", id_valid, exp_iv);
        if (exp_rv) check("req_addr", imem_req_addr, pc_in);
        if (exp_iv) begin
            check("id_pc", id_pc, mq[0].pc);
            check("id_instr", id_instr, mq[0].instr);
        end
        if (redirect) begin
            unf = 0;
            foreach (mq[i]) if (!mq[i].filled) unf++;
            m_drop = m_drop + unf;
            if (imem_rsp_valid && m_drop > 0) m_drop--;
            mq.delete();
        end else begin
            if (imem_rsp_valid) begin
                if (m_drop > 0) m_drop--;
                else begin
                    for (int i = 0; i < mq.size(); i++) begin
                        if (!mq[i].filled) begin
                            mq[i].instr  = imem_rsp_data;
                            mq[i].filled = 1'b1;
                            break;
                        end
                    end
                end
            end
            if (exp_iv && id_ready) mq.delete(0);
            if (exp_pe) mq.push_back('{pc: pc_in, instr: 32'h0, filled: 1'b0});
        end
    endtask

    task automatic mem_drive();
        if (memq.size() > 0 && memq[0].due <= cyc && (rsp_always || $urandom_range(0, 3) != 0)) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(memq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    endtask

    // One clock: entered just after a falling edge with inputs applied, returns at the next one.
    task automatic cycle();
        logic pe;
        if (auto_mem) mem_drive();
        #1;
        pe         = pc_en;
        last_pe    = pc_en;
        last_rv    = imem_req_valid;
        last_iv    = id_valid;
        last_pc    = id_pc;
        last_instr = id_instr;
        model_step();
        if (auto_mem) begin
            if (imem_rsp_valid) memq.delete(0);
            if (pe) memq.push_back('{addr: pc_in, due: cyc + $urandom_range(lat_lo, lat_hi)});
        end
        cyc++;
        @(negedge clk);
        if (auto_pc && pe && !redirect) pc_in = pc_in + 32'd4;
        if (!auto_mem) imem_rsp_valid = 1'b0;
    endtask

    task automatic rsp(input logic [31:0] a);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = instr_of(a);
    endtask

    task automatic apply_reset();
        rst_n = 1'b1;
        #1;
        check("rst_req_valid", imem_req_valid, 1'b0);
        check("rst_pc_en", pc_en, 1'b0);
        check("rst_id_valid", id_valid, 1'b0);
        mq.delete();
        m_drop = 0;
        memq.delete();
        redirect       = 1'b0;
        imem_rsp_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
    endtask

    typedef struct {
        logic [31:0] pc;
        bit          ready;
        bit          rsp_v;
        logic [31:0] rsp_pc;
        bit          id_rdy;
        bit          e_rv;
        bit          e_pe;
        bit          e_iv;
        logic [31:0] e_pc;
    } vec_t;
    vec_t vecs [10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] got_pcs[$];
        int          pulses;
        bit          seen_pe;
        bit          do_redir;

        // pc, ready, rsp_v, rsp_pc, id_rdy | req_valid, pc_en, id_valid, id_pc
        vecs[0] = '{32'd0,  1, 0, 32'd0,  1, 1, 1, 0, 32'd0};
        vecs[1] = '{32'd4,  1, 1, 32'd0,  1, 1, 1, 0, 32'd0};
        vecs[2] = '{32'd8,  1, 1, 32'd4,  1, 1, 1, 1, 32'd0};
        vecs[3] = '{32'd12, 1, 1, 32'd8,  1, 1, 1, 1, 32'd4};
        vecs[4] = '{32'd16, 1, 1, 32'd12, 1, 1, 1, 1, 32'd8};
        vecs[5] = '{32'd20, 0, 1, 32'd16, 1, 1, 0, 1, 32'd12};
        vecs[6] = '{32'd20, 1, 0, 32'd0,  1, 1, 1, 1, 32'd16};
        vecs[7] = '{32'd24, 0, 1, 32'd20, 1, 1, 0, 0, 32'd0};
        vecs[8] = '{32'd24, 0, 0, 32'd0,  1, 1, 0, 1, 32'd20};
        vecs[9] = '{32'd24, 0, 0, 32'd0,  1, 1, 0, 0, 32'd0};

        pc_in          = 32'h0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect       = 1'b0;
        id_ready       = 1'b1;
        @(negedge clk);
        apply_reset();

        // Streaming fetch with one-cycle memory, then a short stall pattern.
        for (int i = 0; i < 10; i++) begin
            pc_in          = vecs[i].pc;
            imem_req_ready = vecs[i].ready;
            id_ready       = vecs[i].id_rdy;
            if (vecs[i].rsp_v) rsp(vecs[i].rsp_pc);
            cycle();
            check($sformatf("t1_req_valid[%0d]", i), last_rv, vecs[i].e_rv);
            check($sformatf("t1_pc_en[%0d]", i), last_pe, vecs[i].e_pe);
            check($sformatf("t1_id_valid[%0d]", i), last_iv, vecs[i].e_iv);
            if (vecs[i].e_iv) begin
                check($sformatf("t1_id_pc[%0d]", i), last_pc, vecs[i].e_pc);
                check($sformatf("t1_id_instr[%0d]", i), last_instr, instr_of(vecs[i].e_pc));
            end
        end

        // Queue fills while decode stalls, then drains in order.
        auto_mem = 1; auto_pc = 1; rsp_always = 1; lat_lo = 1; lat_hi = 1;
        id_ready = 1'b0; imem_req_ready = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            pulses += int'(last_pe);
        end
        check("t2_pc_en_pulses", pulses, 4);
        check("t2_full_req_valid", last_rv, 1'b0);
        check("t2_full_pc_en", last_pe, 1'b0);
        check("t2_full_head_pc", last_pc, 32'd24);
        id_ready = 1'b1;
        seen_pe  = 0;
        for (int i = 0; i < 20 && got_pcs.size() < 4; i++) begin
            cycle();
            if (last_iv) got_pcs.push_back(last_pc);
            if (last_pe) seen_pe = 1;
        end
        check("t2_drain_count", got_pcs.size(), 4);
        for (int i = 0; i < got_pcs.size(); i++)
            check($sformatf("t2_drain_pc[%0d]", i), got_pcs[i], 32'd24 + 32'(4 * i));
        check("t2_fetch_resumed", seen_pe, 1'b1);

        // Redirect with two requests in flight: both stale responses are discarded.
        apply_reset();
        auto_mem = 0; auto_pc = 0; id_ready = 1'b1; imem_req_ready = 1'b1;
        pc_in = 32'h40; cycle(); check("t3_pe0", last_pe, 1'b1);
        pc_in = 32'h44; cycle(); check("t3_pe1", last_pe, 1'b1);
        pc_in = 32'h48; redirect = 1'b1; cycle();
        check("t3_redir_req_valid", last_rv, 1'b0);
        check("t3_redir_pc_en", last_pe, 1'b0);
        redirect = 1'b0;
        pc_in = 32'h100; rsp(32'h40); cycle();
        check("t3_new_pc_en", last_pe, 1'b1);
        check("t3_drop0_id_valid", last_iv, 1'b0);
        imem_req_ready = 1'b0; pc_in = 32'h104;
        rsp(32'h44); cycle(); check("t3_drop1_id_valid", last_iv, 1'b0);
        rsp(32'h100); cycle(); check("t3_rsp_cycle_id_valid", last_iv, 1'b0);
        cycle();
        check("t3_kept_id_valid", last_iv, 1'b1);
        check("t3_kept_id_pc", last_pc, 32'h100);
        check("t3_kept_id_instr", last_instr, instr_of(32'h100));

        // Memory refuses requests: PC must hold until the first accept.
        imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check($sformatf("t4_stall_pc_en[%0d]", i), last_pe, 1'b0);
            check($sformatf("t4_stall_req_valid[%0d]", i), last_rv, 1'b1);
        end
        imem_req_ready = 1'b1; cycle(); check("t4_accept_pc_en", last_pe, 1'b1);
        imem_req_ready = 1'b0; rsp(32'h104); cycle();
        cycle();
        check("t4_id_pc", last_pc, 32'h104);
        check("t4_id_valid", last_iv, 1'b1);

        // Redirect coinciding with a response and a would-be dequeue.
        apply_reset();
        id_ready = 1'b1; imem_req_ready = 1'b1;
        pc_in = 32'h200; cycle();
        pc_in = 32'h204; cycle();
        pc_in = 32'h208; rsp(32'h200); cycle();
        pc_in = 32'h20c; rsp(32'h204); redirect = 1'b1; cycle();
        check("t5_redir_id_valid", last_iv, 1'b0);
        check("t5_redir_req_valid", last_rv, 1'b0);
        redirect = 1'b0;
        pc_in = 32'h300; rsp(32'h208); cycle();
        check("t5_new_pc_en", last_pe, 1'b1);
        check("t5_drop_id_valid", last_iv, 1'b0);
        imem_req_ready = 1'b0; rsp(32'h300); cycle();
        check("t5_rsp_cycle_id_valid", last_iv, 1'b0);
        cycle();
        check("t5_kept_id_valid", last_iv, 1'b1);
        check("t5_kept_id_pc", last_pc, 32'h300);
        check("t5_kept_id_instr", last_instr, instr_of(32'h300));

        // Reset asserted with three filled entries.
        apply_reset();
        id_ready = 1'b0; imem_req_ready = 1'b1;
        pc_in = 32'h400; cycle();
        pc_in = 32'h404; rsp(32'h400); cycle();
        pc_in = 32'h408; rsp(32'h404); cycle();
        imem_req_ready = 1'b0; rsp(32'h408); cycle();
        imem_req_ready = 1'b1; id_ready = 1'b1; pc_in = 32'h40c;
        #1;
        check("t6_pre_reset_id_valid", id_valid, 1'b1);
        apply_reset();
        pc_in = 32'h500; imem_req_ready = 1'b1; cycle();
        check("t6_post_pc_en", last_pe, 1'b1);
        check("t6_post_id_valid", last_iv, 1'b0);
        imem_req_ready = 1'b0; rsp(32'h500); cycle();
        cycle();
        check("t6_post_id_valid2", last_iv, 1'b1);
        check("t6_post_id_pc", last_pc, 32'h500);

        // Randomized traffic: variable latency, response gaps, decode stalls, redirects.
        apply_reset();
        auto_mem = 1; auto_pc = 1; rsp_always = 0; lat_lo = 1; lat_hi = 3;
        pc_in = 32'h1000;
        for (int i = 0; i < 2000; i++) begin
            do_redir       = ($urandom_range(0, 11) == 0);
            id_ready       = ($urandom_range(0, 3) != 0);
            imem_req_ready = (memq.size() < DEPTH) && ($urandom_range(0, 3) != 0);
            redirect       = do_redir;
            cycle();
            if (do_redir) begin
                pc_in    = $urandom & 32'h0000_fffc;
                redirect = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
